mem_access_unit: RTL and testbench

//  MEM-stage executor for the control word produced by the decode/control unit.

---
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store executor: one word-memory access per start strobe over req/ack,
// with byte-lane steering, load extension, pipeline stall and timeout abort.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [3:0]  read_byte_i,
  input  logic [3:0]  write_byte_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d, size_q, size_d;
  logic [1:0]    off_q, off_d;
  logic          sext_q, sext_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [3:0]    size_in;
  logic          legal_sz, aligned;
  logic [31:0]   lane, ext, wlanes;

  always_comb begin
    size_in  = mem_read_i ? read_byte_i : write_byte_i;
    legal_sz = (size_in == 4'b0001) || (size_in == 4'b0011) || (size_in == 4'b1111);
    aligned  = (size_in == 4'b1111) ? (addr_i[1:0] == 2'b00) :
               (size_in == 4'b0011) ? !addr_i[0] : 1'b1;
    case (size_in)
      4'b0001: wlanes = {4{wdata_i[7:0]}};
      4'b0011: wlanes = {2{wdata_i[15:0]}};
      default: wlanes = wdata_i;
    endcase
    // Load lane is taken from the offset and size latched at accept time.
    lane = mem_rdata_i >> {off_q, 3'b000};
    case (size_q)
      4'b0001: ext = {{24{sext_q & lane[7]}}, lane[7:0]};
      4'b0011: ext = {{16{sext_q & lane[15]}}, lane[15:0]};
      default: ext = lane;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    size_d      = size_q;
    off_d       = off_q;
    sext_d      = sext_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && (mem_read_i ^ mem_write_i) && legal_sz && aligned) begin
          state_d     = S_REQ;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = mem_write_i;
          mem_addr_d  = {addr_i[31:2], 2'b00};
          mem_be_d    = size_in << addr_i[1:0];
          mem_wdata_d = wlanes;
          size_d      = size_in;
          off_d       = addr_i[1:0];
          sext_d      = sign_ext_i;
        end else if (start_i && (mem_read_i || mem_write_i)) begin
          state_d = S_ERR;
        end
      end
      S_REQ: begin
        // An ack on the final timeout cycle still wins.
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = S_DONE;
          if (!mem_we_q) rdata_d = ext;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          state_d   = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      size_q      <= '0;
      off_q       <= '0;
      sext_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      size_q      <= size_d;
      off_q       <= off_d;
      sext_q      <= sext_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a timeline model (cycle windows per transaction) checked
// every cycle, plus hand-computed literal expectations for the directed vectors.
module tb_mem_access_unit;
  localparam int T = 16;

  logic        clk, rst_n, start, mem_read, mem_write, sign_ext, mem_ack;
  logic [3:0]  read_byte, write_byte;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_req, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [3:0]  mem_be;

  mem_access_unit #(.TIMEOUT(T)) dut (
    .clk_i(clk), .reset_i(rst_n), .start_i(start), .mem_read_i(mem_read),
    .mem_write_i(mem_write), .read_byte_i(read_byte), .write_byte_i(write_byte),
    .sign_ext_i(sign_ext), .addr_i(addr), .wdata_i(wdata), .mem_req_o(mem_req),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .busy_o(busy), .done_o(done),
    .rdata_o(rdata), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each transaction is a set of cycle windows; cycle k = interval after edge k.
  int req_lo = 1, req_hi = 0, busy_lo = 0, busy_hi = -1, t_done = -1, t_err = -1;
  logic [31:0] m_addr, m_wdata, m_rdata = '0;
  logic [3:0]  m_be;
  logic        m_we, m_sx;
  int          m_off, m_nb;

  function automatic int nbytes(input logic [3:0] sz);
    case (sz)
      4'b0001: return 1;
      4'b0011: return 2;
      4'b1111: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ld_val(input logic [31:0] rd, input int off, input int nb,
                                         input logic sx);
    logic [31:0] v, m;
    v = rd >> (8 * off);
    m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v = v & m;
    if (sx && nb < 4 && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  always @(posedge clk) begin
    int nb;
    logic [3:0] sz;
    logic [31:0] w;
    cyc++;
    if (!rst_n) begin
      req_lo = 1; req_hi = 0; busy_lo = 0; busy_hi = -1; t_done = -1; t_err = -1;
      m_rdata = '0;
    end else begin
      if (mem_ack && req_lo <= cyc - 1 && cyc - 1 <= req_hi && t_done < 0) begin
        req_hi = cyc - 1; t_err = -1; t_done = cyc; busy_hi = cyc;
        if (!m_we) m_rdata = ld_val(mem_rdata, m_off, m_nb, m_sx);
      end
      if (start && cyc - 1 > busy_hi && (mem_read || mem_write)) begin
        sz = mem_read ? read_byte : write_byte;
        nb = nbytes(sz);
        busy_lo = cyc; t_done = -1;
        if ((mem_read && mem_write) || nb == 0 || (addr % nb) != 0) begin
          t_err = cyc; busy_hi = cyc; req_lo = cyc + 1; req_hi = cyc;
        end else begin
          req_lo = cyc; req_hi = cyc + T - 1; t_err = cyc + T; busy_hi = cyc + T;
          m_nb = nb; m_off = addr % 4; m_sx = sign_ext; m_we = mem_write;
          m_addr = addr - (addr % 4);
          m_be = 4'(((1 << nb) - 1) << m_off);
          w = wdata;
          m_wdata = (nb == 1) ? (w & 32'hFF) * 32'h0101_0101 :
                    (nb == 2) ? (w & 32'hFFFF) * 32'h0001_0001 : w;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      logic e_req;
      e_req = (req_lo <= cyc && cyc <= req_hi);
      chk("m_req", mem_req, e_req);
      chk("m_busy", busy, busy_lo <= cyc && cyc <= busy_hi);
      chk("m_done", done, cyc == t_done);
      chk("m_err", err, cyc == t_err);
      chk("m_rdata", rdata, m_rdata);
      if (e_req) begin
        chk("m_addr", mem_addr, m_addr);
        chk("m_be", mem_be, m_be);
        chk("m_we", mem_we, m_we);
        chk("m_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first cycle after the accepting edge.
  task automatic issue(input logic rd, input logic wr, input logic [3:0] sz, input logic sx,
                       input logic [31:0] ad, input logic [31:0] wd);
    start = 1'b1; mem_read = rd; mem_write = wr; read_byte = sz; write_byte = sz;
    sign_ext = sx; addr = ad; wdata = wd;
    @(negedge clk);
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic ack_after(input int w, input logic [31:0] d);
    repeat (w) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = d;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; sign_ext = 1'b0;
    read_byte = '0; write_byte = '0; addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 0); chk("rst_busy", busy, 0); chk("rst_rdata", rdata, 0);
    chk("rst_done_err", {done, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1, 0, 4'b0001, 1, 32'h103, 0);
    chk("lb_req", mem_req, 1); chk("lb_be", mem_be, 4'b1000); chk("lb_addr", mem_addr, 32'h100);
    ack_after(0, 32'h80FF_1234);
    chk("lb_done", done, 1); chk("lb_rdata", rdata, 32'hFFFF_FF80);
    @(negedge clk);
    chk("lb_idle", busy, 0);

    issue(1, 0, 4'b0001, 0, 32'h103, 0);
    ack_after(0, 32'h80FF_1234);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    @(negedge clk);

    issue(1, 0, 4'b0011, 1, 32'h102, 0);
    ack_after(1, 32'h7FFE_0000);
    chk("lh_rdata", rdata, 32'h0000_7FFE);
    @(negedge clk);

    issue(0, 1, 4'b0011, 0, 32'h202, 32'h0000_BEEF);
    chk("sh_we", mem_we, 1); chk("sh_addr", mem_addr, 32'h200);
    chk("sh_be", mem_be, 4'b1100); chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    ack_after(2, 32'h0);
    chk("sh_done", done, 1); chk("sh_rdata_hold", rdata, 32'h0000_7FFE);
    @(negedge clk);

    issue(0, 1, 4'b1111, 0, 32'h301, 32'h1);
    chk("sw_mis_err", err, 1); chk("sw_mis_req", mem_req, 0); chk("sw_mis_busy", busy, 1);
    @(negedge clk);
    chk("sw_mis_busy1", busy, 0);

    issue(1, 0, 4'b0111, 0, 32'h100, 0);
    chk("bad_size_err", err, 1);
    @(negedge clk);
    issue(1, 1, 4'b0001, 0, 32'h100, 0);
    chk("rw_err", err, 1);
    @(negedge clk);
    issue(0, 0, 4'b0001, 0, 32'h100, 0);
    chk("nop_busy", busy, 0);
    @(negedge clk);

    issue(0, 1, 4'b0001, 0, 32'h001, 32'h1234_5678);
    chk("sb_be", mem_be, 4'b0010); chk("sb_wdata", mem_wdata, 32'h7878_7878);
    ack_after(0, 32'h0);
    @(negedge clk);

    // Word load with wait states; a start during the access must be ignored.
    issue(1, 0, 4'b1111, 0, 32'h010, 0);
    @(negedge clk);
    start = 1'b1; mem_write = 1'b1; write_byte = 4'b0001; addr = 32'h3;
    @(negedge clk);
    start = 1'b0; mem_write = 1'b0;
    ack_after(1, 32'hDEAD_BEEF);
    chk("lw_rdata", rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("lw_ignored_start", busy, 0);

    issue(1, 0, 4'b0011, 1, 32'h006, 0);
    ack_after(0, 32'h8001_0000);
    chk("lh_neg", rdata, 32'hFFFF_8001);
    @(negedge clk);

    issue(1, 0, 4'b1111, 0, 32'h040, 0);
    n = 0;
    while (mem_req && n < 40) begin @(negedge clk); n++; end
    chk("to_cycles", n, T); chk("to_err", err, 1); chk("to_rdata", rdata, 32'hFFFF_8001);
    @(negedge clk);

    issue(1, 0, 4'b1111, 0, 32'h044, 0);
    ack_after(T - 1, 32'h0BAD_F00D);
    chk("ack16_done", done, 1); chk("ack16_err", err, 0); chk("ack16_rdata", rdata, 32'h0BAD_F00D);
    @(negedge clk);

    issue(1, 0, 4'b1111, 0, 32'h048, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_req", mem_req, 0); chk("rst_mid_busy", busy, 0); chk("rst_mid_done", done, 0);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_done", done, 0);
    @(negedge clk);
    chk("late_ack_rdata", rdata, 32'h0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
